// File: rtl/ga23_sdr_responder.sv
// GA23 tile-ROM fetch responder: turns one toggle-handshake 64-bit read request
// into four 16-bit memory reads, with a one-line last-line hit path.
module ga23_sdr_responder #(
  parameter int ADDR_W   = 25,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sdr_addr,
  input  logic              sdr_req,
  output logic              sdr_rdy,
  output logic [63:0]       sdr_data,
  output logic [ADDR_W-2:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [15:0]       mem_din,
  output logic              busy
);

  localparam int LINE_W = ADDR_W - 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIT   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [LINE_W-1:0]   line_reg;
  logic [1:0]          beat_reg;
  logic                req_latched_reg;
  logic [63:0]         staging_reg;
  logic                sdr_rdy_reg;
  logic [63:0]         sdr_data_reg;
  logic                pending;
  logic                tag_hit;
  logic                unused_addr_bits;

  // Byte-offset bits within a 64-bit line carry no information here.
  assign unused_addr_bits = ^sdr_addr[2:0];

  assign pending  = (sdr_req != sdr_rdy_reg);
  assign sdr_rdy  = sdr_rdy_reg;
  assign sdr_data = sdr_data_reg;
  assign mem_addr = {line_reg, beat_reg};

  generate
    if (CACHE_EN) begin : g_tag
      logic [LINE_W-1:0] tag_reg;
      logic              tag_valid_reg;

      // Remember the line most recently delivered in full.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tag_reg       <= '0;
          tag_valid_reg <= 1'b0;
        end else if (state_reg == ST_DONE) begin
          tag_reg       <= line_reg;
          tag_valid_reg <= 1'b1;
        end
      end

      assign tag_hit = tag_valid_reg && (sdr_addr[ADDR_W-1:3] == tag_reg);
    end else begin : g_no_tag
      assign tag_hit = 1'b0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (pending) state_next = tag_hit ? ST_HIT : ST_ISSUE;
      ST_HIT:   state_next = ST_IDLE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (mem_ack) state_next = (beat_reg == 2'd3) ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs: read strobe lasts exactly the ISSUE cycle.
  always_comb begin
    mem_rd = (state_reg == ST_ISSUE);
    busy   = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT) || (state_reg == ST_DONE);
  end

  // Datapath: latch request, collect beats in staging, publish whole line at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_reg        <= '0;
      beat_reg        <= 2'd0;
      req_latched_reg <= 1'b0;
      staging_reg     <= '0;
      sdr_rdy_reg     <= 1'b0;
      sdr_data_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pending && !tag_hit) begin
            line_reg        <= sdr_addr[ADDR_W-1:3];
            beat_reg        <= 2'd0;
            req_latched_reg <= sdr_req;
          end
        end
        ST_HIT: begin
          sdr_rdy_reg <= sdr_req;
        end
        ST_WAIT: begin
          if (mem_ack) begin
            staging_reg[{beat_reg, 4'b0000} +: 16] <= mem_din;
            if (beat_reg != 2'd3) beat_reg <= beat_reg + 2'd1;
          end
        end
        ST_DONE: begin
          sdr_data_reg <= staging_reg;
          sdr_rdy_reg  <= req_latched_reg;
          beat_reg     <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ga23_sdr_responder.sv
// Directed bench for ga23_sdr_responder with a simple memory responder model.
module tb_ga23_sdr_responder;

  logic        clk;
  logic        reset;
  logic [24:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_rdy;
  logic [63:0] sdr_data;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [15:0] mem_din;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [23:0] rd_log[$];
  logic [15:0] beat_data[4];
  int          ack_delay = 1;
  bit          use_fn = 0;

  ga23_sdr_responder #(.ADDR_W(25), .CACHE_EN(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .sdr_addr (sdr_addr),
    .sdr_req  (sdr_req),
    .sdr_rdy  (sdr_rdy),
    .sdr_data (sdr_data),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_ack  (mem_ack),
    .mem_din  (mem_din),
    .busy     (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: answers each read strobe after ack_delay clocks.
  initial begin
    mem_ack = 0;
    mem_din = 0;
    forever begin
      @(posedge clk); #1;
      while (mem_rd) begin
        rd_log.push_back(mem_addr);
        repeat (ack_delay) begin @(posedge clk); #1; end
        mem_ack = 1;
        mem_din = use_fn ? {mem_addr[11:0], 4'hC} : beat_data[mem_addr[1:0]];
        @(posedge clk); #1;
        mem_ack = 0;
      end
    end
  end

  // Issue one request and wait (bounded) for completion; call at posedge+1.
  task automatic do_req(input logic [24:0] a, output int lat, output int nrd, output int early);
    int base;
    logic [63:0] prev;
    base  = rd_log.size();
    prev  = sdr_data;
    early = 0;
    lat   = 0;
    sdr_addr = a;
    sdr_req  = ~sdr_req;
    while (sdr_rdy !== sdr_req && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (sdr_rdy !== sdr_req && sdr_data !== prev) early++;
    end
    nrd = rd_log.size() - base;
    $display("txn addr=0x%07h lat=%0d reads=%0d data=0x%016h rdy=%0b", a, lat, nrd, sdr_data, sdr_rdy);
  endtask

  initial begin
    int lat, nrd, early, base, n;
    logic old_rdy;

    reset = 1; sdr_req = 0; sdr_addr = '0;
    beat_data[0] = 16'h1111; beat_data[1] = 16'h2222;
    beat_data[2] = 16'h3333; beat_data[3] = 16'h4444;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", sdr_rdy, 0);
    check("rst_data", sdr_data, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    reset = 0;
    @(posedge clk); #1;

    // 1: first fetch from memory
    base = rd_log.size();
    do_req(25'h000_0100, lat, nrd, early);
    check("t1_lat", lat, 10);
    check("t1_nrd", nrd, 4);
    check("t1_data", sdr_data, 64'h4444_3333_2222_1111);
    check("t1_rdy", sdr_rdy, 1);
    check("t1_addr0", rd_log[base], 24'h80);
    check("t1_addr3", rd_log[base+3], 24'h83);
    check("t1_busy_end", busy, 0);

    // 2: repeat of same line hits
    do_req(25'h000_0100, lat, nrd, early);
    check("t2_lat", lat, 2);
    check("t2_nrd", nrd, 0);
    check("t2_rdy", sdr_rdy, 0);
    check("t2_data", sdr_data, 64'h4444_3333_2222_1111);

    // 3: same line different byte offset hits; next line misses
    do_req(25'h000_0104, lat, nrd, early);
    check("t3a_lat", lat, 2);
    check("t3a_nrd", nrd, 0);
    base = rd_log.size();
    do_req(25'h000_0108, lat, nrd, early);
    check("t3b_lat", lat, 10);
    check("t3b_nrd", nrd, 4);
    check("t3b_addr0", rd_log[base], 24'h84);

    // 4: slow memory, data must not change mid-fill
    ack_delay = 5;
    beat_data[0] = 16'hAAAA; beat_data[1] = 16'hBBBB;
    beat_data[2] = 16'hCCCC; beat_data[3] = 16'hDDDD;
    do_req(25'h000_0180, lat, nrd, early);
    check("t4_lat", lat, 26);
    check("t4_early", early, 0);
    check("t4_data", sdr_data, 64'hDDDD_CCCC_BBBB_AAAA);

    // 5: reset during beat 2, then previously cached line must miss
    ack_delay = 1;
    beat_data[0] = 16'h1111; beat_data[1] = 16'h2222;
    beat_data[2] = 16'h3333; beat_data[3] = 16'h4444;
    base = rd_log.size();
    sdr_addr = 25'h000_0400;
    sdr_req  = ~sdr_req;
    n = 0;
    while (rd_log.size() < base + 3 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("t5_reach_beat2", (rd_log.size() >= base + 3), 1);
    reset = 1;
    sdr_req = 0;
    @(posedge clk); @(posedge clk); #1;
    check("t5_rdy", sdr_rdy, 0);
    check("t5_data", sdr_data, 0);
    check("t5_busy", busy, 0);
    check("t5_mem_rd", mem_rd, 0);
    check("t5_mem_addr", mem_addr, 0);
    reset = 0;
    @(posedge clk); #1;
    do_req(25'h000_0180, lat, nrd, early);
    check("t5_miss_nrd", nrd, 4);
    check("t5_miss_lat", lat, 10);
    check("t5_miss_data", sdr_data, 64'h4444_3333_2222_1111);

    // 6: second request raised while busy is served afterwards, in order
    use_fn = 1;
    old_rdy = sdr_rdy;
    base = rd_log.size();
    sdr_addr = 25'h000_0200;
    sdr_req  = ~sdr_req;
    repeat (3) begin @(posedge clk); #1; end
    check("t6_busy_mid", busy, 1);
    sdr_addr = 25'h000_0308;
    sdr_req  = ~sdr_req;
    n = 0;
    while (sdr_rdy === old_rdy && n < 200) begin @(posedge clk); #1; n++; end
    $display("txn addr=0x0000200 data=0x%016h rdy=%0b", sdr_data, sdr_rdy);
    check("t6_first_data", sdr_data, 64'h103C_102C_101C_100C);
    n = 0;
    while (sdr_rdy !== sdr_req && n < 200) begin @(posedge clk); #1; n++; end
    $display("txn addr=0x0000308 data=0x%016h rdy=%0b", sdr_data, sdr_rdy);
    check("t6_second_data", sdr_data, 64'h187C_186C_185C_184C);
    check("t6_nrd", rd_log.size() - base, 8);
    check("t6_addr_first", rd_log[base], 24'h100);
    check("t6_addr_second", rd_log[base+4], 24'h184);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
